seq_match_ctrl: RTL and testbench
=================================

Name: seq_match_ctrl

Overview:
- Programmable serial pattern-match controller.
- Configures the pattern, length and overlap mode, then sequences a detection run over a valid-qualified serial bit stream.
- Counts matches and stops when a programmed match count is reached.
- Replaces fixed-pattern FSM detectors wherever software needs run-time pattern selection and run control.

Parameters:
MAXLEN, 8, maximum pattern length in bits (2..16)
LEN_W, 4, width of cfg_len; must hold the value MAXLEN
CNT_W, 8, width of match counter and target

Ports:
clk  in  1  rising-edge clock
rst  in  1  asynchronous active-high reset
cfg_we  in  1  config write strobe
cfg_pattern  in  MAXLEN  pattern; bit [len-1] is the first bit received, bit [0] the last
cfg_len  in  LEN_W  pattern length
cfg_overlap  in  1  1 = overlapping matches allowed
cfg_target  in  CNT_W  number of matches that ends a run; 0 = free-running
start  in  1  begin run
abort  in  1  terminate run
x  in  1  serial data bit
x_valid  in  1  x is valid this cycle
z  out  1  one-cycle match pulse
busy  out  1  high in RUN
done  out  1  high in DONE
match_cnt  out  CNT_W  matches counted this run

Behaviour:
- Reset (async, rst=1):
  - State = IDLE.
  - z=0, busy=0, done=0, match_cnt=0.
  - Config registers: pattern=0, len=0, overlap=0, target=0.
  - History register and fill counter cleared.
- FSM states: IDLE, RUN, DONE.
  - IDLE/DONE + start -> RUN: clears match_cnt, history and fill; done drops on the same edge.
  - RUN + abort -> IDLE: match_cnt holds.
  - RUN + match where match_cnt+1 == target (target != 0) -> DONE on that edge.
  - DONE holds until start.
- Configuration:
  - cfg_we is sampled only in IDLE or DONE, and is ignored in RUN.
  - cfg_len > MAXLEN is clamped to MAXLEN on write.
  - len 0 or 1 is legal; len 0 never matches.
- Detection (RUN only; x_valid is ignored elsewhere):
  - On each accepted bit: hist <= {hist[MAXLEN-2:0], x}.
  - fill increments, saturating at MAXLEN.
  - Match = ({hist[len-2:0], x} == pattern[len-1:0]) and (fill+1 >= len).
  - For len=1, the match test is x == pattern[0].
- Registered outputs:
  - On the accepting edge of a matching bit: z <= 1 for exactly one cycle, and match_cnt increments.
  - Latency from the final pattern bit being sampled to z is one clock.
- Overlap modes:
  - cfg_overlap=1: fill keeps counting after a match, so a suffix of the match can begin the next match.
  - cfg_overlap=0: fill resets to 0 on a match, so the next match needs len fresh bits.
- match_cnt saturates at all-ones; with target=0 the run never enters DONE.
- Simultaneous events:
  - start with abort in IDLE/DONE: start wins.
  - abort in RUN with a matching bit: abort wins; no z pulse, no count.
  - start in RUN: ignored.
- x_valid low: no shift, no fill change, no match.
- Reset asserted mid-run returns everything to the reset values immediately, without waiting for a clock edge.

Optional Feature:
- Macro: SEQ_TIMEOUT_EN.
- When defined:
  - Adds parameter TO_W (default 16) and input to_limit[TO_W-1:0].
  - Adds output timeout (reset 0).
  - A cycle counter runs in RUN and clears on start and on every match.
  - When the counter reaches to_limit (nonzero), the FSM goes to DONE with timeout=1. timeout clears on start.
  - to_limit=0 disables the timeout.
- When not defined: these ports and the counter are absent, and a RUN ends only by target or abort.

Test Plan:
- Reset then idle: rst pulse mid-cycle -> outputs 0 asynchronously; x_valid toggling in IDLE -> z stays 0, match_cnt stays 0.
- Overlapping match: pattern=4'b0110, len=4, overlap=1, target=0, stream 0,1,1,0,1,1,0 -> z pulses one cycle after bits 4 and 7; match_cnt=2; busy stays 1.
- Non-overlapping match: same stream with overlap=0 -> single z after bit 4; match_cnt=1. Then target=2 with stream 0110 0110 -> done=1 and busy=0 one cycle after bit 8.
- Gaps and aborts:
  - x_valid gaps inside the pattern (0,gap,1,1,gap,0) -> still one match.
  - abort on the cycle of the final 0 -> no z, match_cnt unchanged, state IDLE.
- Config guarding: cfg_we in RUN with pattern=4'b1111 -> ignored, detection stays on 0110. cfg_len=12 with MAXLEN=8 -> len reads/behaves as 8. len=0 -> no match on any stream.
- SEQ_TIMEOUT_EN: to_limit=5, no match for 5 cycles after start -> done=1, timeout=1. A match at cycle 3 restarts the count.

Source files
------------

// File: rtl/seq_match_ctrl.sv
// -----------------------------------------------------------------------------
// seq_match_ctrl - programmable serial pattern-match controller
//
// Software loads a pattern, its length, an overlap mode and a target match
// count, then starts a run. During RUN each valid serial bit is shifted into a
// history register and compared against the pattern. Every match gives a
// one-cycle pulse on z and bumps match_cnt. The run ends when match_cnt reaches
// the target (non-zero), or when abort is asserted.
//
// Optional feature (macro SEQ_TIMEOUT_EN): adds parameter TO_W, input
// to_limit and output timeout. When enabled, a run also ends after to_limit
// RUN cycles without a match.
//
// Ports:
//   clk, rst             rising-edge clock, asynchronous active-high reset
//   cfg_we               config write strobe (honoured in IDLE/DONE only)
//   cfg_pattern          pattern; bit [len-1] is received first, bit [0] last
//   cfg_len              pattern length (clamped to MAXLEN on write)
//   cfg_overlap          1 = overlapping matches allowed
//   cfg_target           match count that ends a run; 0 = free-running
//   start, abort         run control
//   x, x_valid           serial data bit and its qualifier
//   z                    one-cycle match pulse
//   busy, done           high in RUN / DONE
//   match_cnt            matches counted this run (saturating)
//   to_limit, timeout    (SEQ_TIMEOUT_EN only) idle-cycle limit and flag
// -----------------------------------------------------------------------------
module seq_match_ctrl #(
  parameter int MAXLEN = 8,
  parameter int LEN_W  = 4,
  parameter int CNT_W  = 8
`ifdef SEQ_TIMEOUT_EN
  , parameter int TO_W = 16
`endif
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cfg_we,
  input  logic [MAXLEN-1:0] cfg_pattern,
  input  logic [LEN_W-1:0]  cfg_len,
  input  logic              cfg_overlap,
  input  logic [CNT_W-1:0]  cfg_target,
  input  logic              start,
  input  logic              abort,
  input  logic              x,
  input  logic              x_valid,
`ifdef SEQ_TIMEOUT_EN
  input  logic [TO_W-1:0]   to_limit,
  output logic              timeout,
`endif
  output logic              z,
  output logic              busy,
  output logic              done,
  output logic [CNT_W-1:0]  match_cnt
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t              r_state;
  state_t              w_state_next;

  logic [MAXLEN-1:0]   r_pattern;
  logic [LEN_W-1:0]    r_len;
  logic                r_overlap;
  logic [CNT_W-1:0]    r_target;

  logic [MAXLEN-1:0]   r_hist;
  logic [LEN_W-1:0]    r_fill;
  logic                r_z;
  logic [CNT_W-1:0]    r_cnt;

  logic                w_accept;
  logic                w_start_run;
  logic [MAXLEN-1:0]   w_window;
  logic [MAXLEN-1:0]   w_mask;
  logic                w_bits_eq;
  logic                w_fill_ok;
  logic                w_match;
  logic                w_hit_target;
  logic [CNT_W-1:0]    w_cnt_inc;

  // Abort has priority over a matching bit, so it blocks acceptance outright.
  assign w_accept    = (r_state == S_RUN) && x_valid && !abort;
  assign w_start_run = (r_state != S_RUN) && start;

  // Candidate window including the bit arriving this cycle.
  assign w_window = {r_hist[MAXLEN-2:0], x};

  // Only the low len bits take part in the comparison.
  for (genvar gi = 0; gi < MAXLEN; gi++) begin : g_mask
    assign w_mask[gi] = (r_len > LEN_W'(gi));
  end

  assign w_bits_eq = (((w_window ^ r_pattern) & w_mask) == '0);
  // Extra bit keeps fill+1 from wrapping when MAXLEN fills the LEN_W range.
  assign w_fill_ok = ((LEN_W+1)'(r_fill) + (LEN_W+1)'(1)) >= (LEN_W+1)'(r_len);
  assign w_match   = w_accept && (r_len != '0) && w_bits_eq && w_fill_ok;

  assign w_cnt_inc    = (r_cnt == '1) ? r_cnt : r_cnt + CNT_W'(1);
  assign w_hit_target = w_match && (r_target != '0) &&
                        (((CNT_W+1)'(r_cnt) + (CNT_W+1)'(1)) == (CNT_W+1)'(r_target));

`ifdef SEQ_TIMEOUT_EN
  logic [TO_W-1:0] r_to_cnt;
  logic            r_timeout;
  logic            w_to_hit;

  // Fires on the cycle that completes to_limit RUN cycles since start or the
  // last match; a match or abort on that same cycle takes precedence.
  assign w_to_hit = (r_state == S_RUN) && !abort && !w_match && (to_limit != '0) &&
                    (((TO_W+1)'(r_to_cnt) + (TO_W+1)'(1)) == (TO_W+1)'(to_limit));
  assign timeout  = r_timeout;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_to_cnt  <= '0;
      r_timeout <= 1'b0;
    end else if (w_start_run) begin
      r_to_cnt  <= '0;
      r_timeout <= 1'b0;
    end else if (r_state == S_RUN) begin
      if (w_match)
        r_to_cnt <= '0;
      else if (r_to_cnt != '1)
        r_to_cnt <= r_to_cnt + TO_W'(1);
      if (w_to_hit)
        r_timeout <= 1'b1;
    end
  end
`endif

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      r_state <= S_IDLE;
    else
      r_state <= w_state_next;
  end

  // Next-state logic
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE, S_DONE: begin
        if (start)
          w_state_next = S_RUN;
      end
      S_RUN: begin
        if (abort)
          w_state_next = S_IDLE;
        else if (w_hit_target)
          w_state_next = S_DONE;
`ifdef SEQ_TIMEOUT_EN
        else if (w_to_hit)
          w_state_next = S_DONE;
`endif
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  // Configuration, history, fill and match bookkeeping
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pattern <= '0;
      r_len     <= '0;
      r_overlap <= 1'b0;
      r_target  <= '0;
      r_hist    <= '0;
      r_fill    <= '0;
      r_z       <= 1'b0;
      r_cnt     <= '0;
    end else begin
      r_z <= w_match;

      if (cfg_we && (r_state != S_RUN)) begin
        r_pattern <= cfg_pattern;
        r_len     <= (cfg_len > LEN_W'(MAXLEN)) ? LEN_W'(MAXLEN) : cfg_len;
        r_overlap <= cfg_overlap;
        r_target  <= cfg_target;
      end

      if (w_start_run) begin
        r_hist <= '0;
        r_fill <= '0;
        r_cnt  <= '0;
      end else if (w_accept) begin
        r_hist <= w_window;
        // Non-overlap mode forgets the matched bits by restarting fill.
        if (w_match && !r_overlap)
          r_fill <= '0;
        else if (r_fill != LEN_W'(MAXLEN))
          r_fill <= r_fill + LEN_W'(1);
        if (w_match)
          r_cnt <= w_cnt_inc;
      end
    end
  end

  assign z         = r_z;
  assign busy      = (r_state == S_RUN);
  assign done      = (r_state == S_DONE);
  assign match_cnt = r_cnt;

endmodule

// File: tb/tb_seq_match_ctrl.sv
// -----------------------------------------------------------------------------
// tb_seq_match_ctrl - directed scoreboard bench for seq_match_ctrl
//
// Stimulus pushes each expected z pulse (cycle and match_cnt) into a queue;
// an independent monitor pops and compares whenever z is seen high.
// -----------------------------------------------------------------------------
module tb_seq_match_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       cfg_we = 1'b0;
  logic [7:0] cfg_pattern = '0;
  logic [3:0] cfg_len = '0;
  logic       cfg_overlap = 1'b0;
  logic [7:0] cfg_target = '0;
  logic       start = 1'b0;
  logic       abort = 1'b0;
  logic       x = 1'b0;
  logic       x_valid = 1'b0;
  logic       z;
  logic       busy;
  logic       done;
  logic [7:0] match_cnt;
`ifdef SEQ_TIMEOUT_EN
  logic [15:0] to_limit = '0;
  logic        timeout;
`endif

  seq_match_ctrl dut (
    .clk         (clk),
    .rst         (rst),
    .cfg_we      (cfg_we),
    .cfg_pattern (cfg_pattern),
    .cfg_len     (cfg_len),
    .cfg_overlap (cfg_overlap),
    .cfg_target  (cfg_target),
    .start       (start),
    .abort       (abort),
    .x           (x),
    .x_valid     (x_valid),
`ifdef SEQ_TIMEOUT_EN
    .to_limit    (to_limit),
    .timeout     (timeout),
`endif
    .z           (z),
    .busy        (busy),
    .done        (done),
    .match_cnt   (match_cnt)
  );

  always #5 clk = ~clk;

  int cyc   = 0;
  int tests = 0;
  int fails = 0;

  always @(posedge clk) cyc++;

  typedef struct {
    int cyc;
    int cnt;
  } exp_t;

  exp_t sb_q[$];
  exp_t m_e;

  // Monitor: every z pulse must correspond to the oldest expected entry.
  always @(negedge clk) begin
    if (!rst && z) begin
      tests++;
      if (sb_q.size() == 0) begin
        fails++;
        $display("[TB] FAIL z_unexpected: z=1 at cycle %0d cnt=%0d, required no pulse", cyc, match_cnt);
      end else begin
        m_e = sb_q.pop_front();
        if (m_e.cyc != cyc || m_e.cnt != int'(match_cnt)) begin
          fails++;
          $display("[TB] FAIL z_pulse: got cycle %0d cnt %0d, required cycle %0d cnt %0d",
                   cyc, match_cnt, m_e.cyc, m_e.cnt);
        end else begin
          $display("[TB] z pulse cycle %0d cnt %0d ok", cyc, match_cnt);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("[TB] FAIL %s: got %0d, required %0d", name, act, exp);
    end else begin
      $display("[TB] check %s = %0d ok", name, act);
    end
  endtask

  // Send one valid bit; m=1 means a z pulse with match_cnt=ecnt is expected.
  task automatic send(input logic b, input bit m, input int ecnt);
    exp_t e;
    x       = b;
    x_valid = 1'b1;
    if (m) begin
      e.cyc = cyc + 1;
      e.cnt = ecnt;
      sb_q.push_back(e);
    end
    tick();
    x_valid = 1'b0;
    x       = 1'b0;
  endtask

  task automatic gap();
    x_valid = 1'b0;
    tick();
  endtask

  task automatic cfg(input logic [7:0] pat, input logic [3:0] len,
                     input logic ovl, input logic [7:0] tgt);
    cfg_we      = 1'b1;
    cfg_pattern = pat;
    cfg_len     = len;
    cfg_overlap = ovl;
    cfg_target  = tgt;
    tick();
    cfg_we = 1'b0;
  endtask

  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic do_abort();
    abort = 1'b1;
    tick();
    abort = 1'b0;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_z", z, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_cnt", match_cnt, 0);
    rst = 1'b0;
    tick();

    // Valid bits in IDLE are ignored
    cfg(8'b0110, 4'd4, 1'b1, 8'd0);
    send(0, 0, 0); send(1, 0, 0); send(1, 0, 0); send(0, 0, 0);
    check("idle_cnt", match_cnt, 0);
    check("idle_busy", busy, 0);

    // Overlapping: 0110110 -> matches after bits 4 and 7
    do_start();
    check("ovl_busy_start", busy, 1);
    send(0, 0, 0); send(1, 0, 0); send(1, 0, 0); send(0, 1, 1);
    send(1, 0, 0); send(1, 0, 0); send(0, 1, 2);
    check("ovl_cnt", match_cnt, 2);
    check("ovl_busy", busy, 1);
    check("ovl_done", done, 0);

    // Non-overlapping: same stream -> one match
    do_abort();
    check("abort_cnt_hold", match_cnt, 2);
    cfg(8'b0110, 4'd4, 1'b0, 8'd0);
    do_start();
    check("start_clears_cnt", match_cnt, 0);
    send(0, 0, 0); send(1, 0, 0); send(1, 0, 0); send(0, 1, 1);
    send(1, 0, 0); send(1, 0, 0); send(0, 0, 0);
    check("novl_cnt", match_cnt, 1);

    // Target 2: DONE right after the 8th bit
    do_abort();
    cfg(8'b0110, 4'd4, 1'b0, 8'd2);
    do_start();
    send(0, 0, 0); send(1, 0, 0); send(1, 0, 0); send(0, 1, 1);
    send(0, 0, 0); send(1, 0, 0); send(1, 0, 0);
    check("tgt_busy_before", busy, 1);
    send(0, 1, 2);
    check("tgt_done", done, 1);
    check("tgt_busy", busy, 0);
    check("tgt_cnt", match_cnt, 2);

    // x_valid gaps inside the pattern
    cfg(8'b0110, 4'd4, 1'b0, 8'd0);
    do_start();
    check("done_drops", done, 0);
    send(0, 0, 0); gap(); send(1, 0, 0); send(1, 0, 0); gap(); send(0, 1, 1);
    check("gap_cnt", match_cnt, 1);

    // Abort on the final matching bit wins
    send(0, 0, 0); send(1, 0, 0); send(1, 0, 0);
    x = 1'b0; x_valid = 1'b1; abort = 1'b1;
    tick();
    x_valid = 1'b0; abort = 1'b0;
    check("abort_match_cnt", match_cnt, 1);
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);

    // cfg_we in RUN is ignored
    do_start();
    cfg(8'b1111, 4'd4, 1'b0, 8'd0);
    send(1, 0, 0); send(1, 0, 0); send(1, 0, 0); send(1, 0, 0);
    send(0, 0, 0); send(1, 0, 0); send(1, 0, 0); send(0, 1, 1);
    check("cfg_run_cnt", match_cnt, 1);

    // Length 12 clamps to 8
    do_abort();
    cfg(8'hB3, 4'd12, 1'b0, 8'd0);
    do_start();
    send(1, 0, 0); send(0, 0, 0); send(1, 0, 0); send(1, 0, 0);
    send(0, 0, 0); send(0, 0, 0); send(1, 0, 0); send(1, 1, 1);
    check("clamp_cnt", match_cnt, 1);

    // Length 0 never matches
    do_abort();
    cfg(8'h00, 4'd0, 1'b1, 8'd0);
    do_start();
    send(0, 0, 0); send(0, 0, 0); send(1, 0, 0); send(0, 0, 0);
    check("len0_cnt", match_cnt, 0);

    // Length 1 matches each 1
    do_abort();
    cfg(8'h01, 4'd1, 1'b1, 8'd0);
    do_start();
    send(1, 1, 1); send(0, 0, 0); send(1, 1, 2);
    check("len1_cnt", match_cnt, 2);

    // start in RUN is ignored
    do_start();
    check("start_in_run_cnt", match_cnt, 2);
    check("start_in_run_busy", busy, 1);

    // Asynchronous reset mid-cycle
    #2 rst = 1'b1;
    #1;
    check("async_rst_busy", busy, 0);
    check("async_rst_cnt", match_cnt, 0);
    check("async_rst_done", done, 0);
    tick();
    rst = 1'b0;
    tick();

    // start together with abort in IDLE: start wins
    cfg(8'h01, 4'd1, 1'b1, 8'd0);
    start = 1'b1; abort = 1'b1;
    tick();
    start = 1'b0; abort = 1'b0;
    check("start_abort_busy", busy, 1);
    send(1, 1, 1);
    check("start_abort_cnt", match_cnt, 1);

    tick();
    tick();
    check("scoreboard_empty", sb_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
